// File: rtl/hazard_ctrl.sv
// Hazard detection, forwarding select and stall watchdog for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriE,
  input  logic             regwriM,
  input  logic             regwriW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             pcsrcD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    BRSTALL = 2'd2
  } state_t;

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             stall_err_q, stall_err_d;
  logic             lwstall, brstall, stall;

  // Register 0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] ex_sel(input logic [4:0] src, input logic rw_m,
                                        input logic [4:0] dst_m, input logic rw_w,
                                        input logic [4:0] dst_w);
    if (rw_m && hit(dst_m, src))
      return 2'b10;
    else if (rw_w && hit(dst_w, src))
      return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    lwstall = memtoregE && (hit(writeregE, rsD) || hit(writeregE, rtD));
    brstall = branchD &&
              ((regwriE   && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
               (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));
    stall   = lwstall || brstall;

    stallF    = 1'b0;
    stallD    = 1'b0;
    flushE    = 1'b1;
    flushD    = 1'b1;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (!rst) begin
      stallF    = stall;
      stallD    = stall;
      flushE    = stall;
      flushD    = pcsrcD && !stall;
      forwardAD = regwriM && hit(writeregM, rsD);
      forwardBD = regwriM && hit(writeregM, rtD);
      forwardAE = ex_sel(rsE, regwriM, writeregM, regwriW, writeregW);
      forwardBE = ex_sel(rtE, regwriM, writeregM, regwriW, writeregW);
    end
  end

  // A stall seen while in RUN opens a new episode, so the run length restarts at 1.
  always_comb begin
    state_d     = lwstall ? LDSTALL : (brstall ? BRSTALL : RUN);
    stall_err_d = stall_err_q || (stall && (run_q == RUN_LAST));
    run_d       = '0;
    if (stall) begin
      if (state_q == RUN)
        run_d = RUN_W'(1);
      else if (run_q == RUN_MAX)
        run_d = run_q;
      else
        run_d = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      run_q       <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign stall_err = stall_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallD && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((flushD || flushE) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios, expected outputs queued per step.
// Counter expectations follow HAZARD_PERF_CNT_EN when it is defined for the build.
module tb_hazard_ctrl;

  localparam int MAX_STALL = 4;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic             regwriE, regwriM, regwriW, memtoregE, memtoregM, branchD, pcsrcD;
  logic             stallF, stallD, flushD, flushE, forwardAD, forwardBD, stall_err;
  logic [1:0]       forwardAE, forwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriE(regwriE), .regwriM(regwriM), .regwriW(regwriW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .pcsrcD(pcsrcD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stall_err(stall_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lw;
    logic       br;
    logic       stall;
    logic       flushD;
    logic       flushE;
    logic       fad;
    logic       fbd;
    logic [1:0] fae;
    logic [1:0] fbe;
  } exp_t;

  exp_t expq[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;
  int   m_run, m_state, m_scnt, m_fcnt;
  logic m_err;

  function automatic logic dep(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] exPick(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (regwriW && dep(writeregW, src)) sel = 2'b01;
    if (regwriM && dep(writeregM, src)) sel = 2'b10;
    return sel;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic useE, useM;
    e    = '0;
    useE = dep(writeregE, rsD) || dep(writeregE, rtD);
    useM = dep(writeregM, rsD) || dep(writeregM, rtD);
    if (rst) begin
      e.flushD = 1'b1;
      e.flushE = 1'b1;
    end else begin
      e.lw     = memtoregE && useE;
      e.br     = branchD && ((regwriE && useE) || (memtoregM && useM));
      e.stall  = e.lw || e.br;
      e.flushE = e.stall;
      e.flushD = pcsrcD && !e.stall;
      e.fad    = regwriM && dep(writeregM, rsD);
      e.fbd    = regwriM && dep(writeregM, rtD);
      e.fae    = exPick(rsE);
      e.fbe    = exPick(rtE);
    end
    return e;
  endfunction

  task automatic modelReset();
    m_run   = 0;
    m_state = 0;
    m_err   = 1'b0;
    m_scnt  = 0;
    m_fcnt  = 0;
    last    = '0;
  endtask

  task automatic modelEdge();
    if (!rst) begin
      if (last.stall) begin
        if (m_run == MAX_STALL - 1) m_err = 1'b1;
        if (m_run < MAX_STALL) m_run++;
      end else begin
        m_run = 0;
      end
      m_state = last.lw ? 1 : (last.br ? 2 : 0);
`ifdef HAZARD_PERF_CNT_EN
      if (last.stall && m_scnt < CNT_MAX) m_scnt++;
      if ((last.flushD || last.flushE) && m_fcnt < CNT_MAX) m_fcnt++;
`endif
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
  endtask

  task automatic applyStimulus(input logic [4:0] rs_d, input logic [4:0] rt_d,
                               input logic [4:0] rs_e, input logic [4:0] rt_e,
                               input logic [4:0] w_e, input logic [4:0] w_m,
                               input logic [4:0] w_w, input logic rw_e, input logic rw_m,
                               input logic rw_w, input logic m_e, input logic m_m,
                               input logic br, input logic pc);
    rsD = rs_d; rtD = rt_d; rsE = rs_e; rtE = rt_e;
    writeregE = w_e; writeregM = w_m; writeregW = w_w;
    regwriE = rw_e; regwriM = rw_m; regwriW = rw_w;
    memtoregE = m_e; memtoregM = m_m; branchD = br; pcsrcD = pc;
    expq.push_back(predict());
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: observed empty scoreboard expected 1 entry", tag);
      return;
    end
    e    = expq.pop_front();
    last = e;
    check({tag, ".stallF"},    stallF,    e.stall);
    check({tag, ".stallD"},    stallD,    e.stall);
    check({tag, ".flushE"},    flushE,    e.flushE);
    check({tag, ".flushD"},    flushD,    e.flushD);
    check({tag, ".forwardAD"}, forwardAD, e.fad);
    check({tag, ".forwardBD"}, forwardBD, e.fbd);
    check({tag, ".forwardAE"}, forwardAE, e.fae);
    check({tag, ".forwardBE"}, forwardBE, e.fbe);
    check({tag, ".stall_err"}, stall_err, m_err);
    check({tag, ".stall_cnt"}, stall_cnt, m_scnt);
    check({tag, ".flush_cnt"}, flush_cnt, m_fcnt);
    check({tag, ".state"},     32'(dut.state_q), m_state);
  endtask

  task automatic step(input string tag);
    #2;
    checkOutput(tag);
    @(posedge clk);
    #1;
    modelEdge();
  endtask

  initial begin
    modelReset();
    rst = 1'b1;
    // hazardous inputs during reset must be masked by the reset override
    applyStimulus(8, 0, 5, 0, 8, 5, 0, 1, 1, 0, 1, 0, 0, 1);
    step("reset0");
    applyStimulus(8, 0, 5, 0, 8, 5, 0, 1, 1, 0, 1, 0, 0, 1);
    step("reset1");
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle");

    $display("[TB] load-use");
    applyStimulus(8, 0, 0, 0, 8, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("lu_stall");
    applyStimulus(8, 0, 0, 0, 0, 8, 0, 0, 1, 0, 0, 1, 0, 0);
    step("lu_release");

    $display("[TB] forward priority");
    applyStimulus(0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 0);
    step("fwd_mem");
    applyStimulus(0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, 0, 0, 0);
    step("fwd_wb");
    applyStimulus(0, 0, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step("fwd_r0");
    applyStimulus(0, 0, 5, 7, 0, 5, 7, 0, 1, 1, 0, 0, 0, 0);
    step("fwd_split");

    $display("[TB] branch after load");
    applyStimulus(3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 1, 0, 1, 0);
    step("bl_ex");
    applyStimulus(3, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 1, 1, 0);
    step("bl_mem");
    applyStimulus(3, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 1, 1);
    step("bl_taken");

    $display("[TB] branch after alu op");
    applyStimulus(0, 9, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    step("ba_stall");
    applyStimulus(0, 9, 0, 0, 0, 9, 0, 0, 1, 0, 0, 0, 1, 1);
    step("ba_taken");

    $display("[TB] watchdog");
    for (int i = 0; i < MAX_STALL; i++) begin
      applyStimulus(0, 8, 0, 0, 8, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      step("wd_hold");
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("wd_sticky");
    end

    $display("[TB] reset mid-stall");
    applyStimulus(8, 0, 0, 0, 8, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("rm_enter");
    rst = 1'b1;
    modelReset();
    applyStimulus(8, 0, 0, 0, 8, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    #1;
    checkOutput("rm_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rm_release");

    $display("[TB] counters");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8, 0, 0, 0, 8, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      step("cnt_stall");
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("cnt_final");
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_sat", stall_cnt, CNT_MAX);
`else
    check("stall_cnt_off", stall_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
